// File: rtl/pic_fetch_sequencer.sv
// pic_fetch_sequencer: PIC16-style fetch / program-flow controller.
// Owns pc, the instruction register and a circular return stack. GOTO, CALL,
// RETURN/RETFIE and RETLW redirect pc and insert one bubble. An ALU skip
// drops the next word and also inserts one bubble.
// Optional build macro STACK_OVF_TRAP_EN: a push at full or a pop at empty
// freezes the sequencer in HALT until reset instead of wrapping.
module pic_fetch_sequencer #(
  parameter int          STACK_DEPTH  = 8,
  parameter logic [10:0] RESET_VECTOR = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] rom_addr,
  input  logic [13:0] rom_data,
  input  logic        stall,
  input  logic        skip,
  output logic [13:0] ir,
  output logic        ir_valid,
  output logic        w_load,
  output logic [7:0]  retlw_k,
  output logic        stack_ovf,
  output logic        stack_unf
);

  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW  = SPW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

`ifdef STACK_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
  typedef enum logic [1:0] {S_PRIME, S_RUN, S_HALT} state_t;
`else
  localparam bit TRAP = 1'b0;
  typedef enum logic {S_PRIME, S_RUN} state_t;
`endif

  state_t state, state_nxt;

  logic [10:0]   pc, pc_nxt;
  logic [13:0]   ir_nxt;
  logic          vld_nxt;
  logic [SPW-1:0] sp, sp_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wl_nxt;
  logic [7:0]    k_nxt;
  logic          ovf_nxt, unf_nxt;
  logic          push_we;
  logic [10:0]   stack [STACK_DEPTH];

  // Decode of the instruction sitting in execute
  logic is_goto, is_call, is_ret, is_retlw, full, empty, trap_hit;
  logic [SPW-1:0] sp_m1;

  assign is_goto  = (ir[13:11] == 3'b101);
  assign is_call  = (ir[13:11] == 3'b100);
  assign is_ret   = (ir == 14'h0008) || (ir == 14'h0009);
  assign is_retlw = (ir[13:10] == 4'b1101);
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign sp_m1    = sp - SP_ONE;
  assign rom_addr = pc;

  // A stack fault only matters when the trap build is selected
  assign trap_hit = TRAP && (state == S_RUN) && !stall && ir_valid &&
                    ((is_call && full) || ((is_ret || is_retlw) && empty));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_PRIME;
    else       state <= state_nxt;
  end

  // Next-state: PRIME leaves on the first unstalled cycle; faults trap to HALT
  always_comb begin
    state_nxt = state;
    case (state)
      S_PRIME: if (!stall) state_nxt = S_RUN;
`ifdef STACK_OVF_TRAP_EN
      S_RUN:   if (trap_hit) state_nxt = S_HALT;
`endif
      default: state_nxt = state;
    endcase
  end

  // Datapath next values: fetch, decode and stack bookkeeping
  always_comb begin
    pc_nxt  = pc;
    ir_nxt  = ir;
    vld_nxt = ir_valid;
    sp_nxt  = sp;
    cnt_nxt = cnt;
    wl_nxt  = 1'b0;
    k_nxt   = retlw_k;
    ovf_nxt = stack_ovf;
    unf_nxt = stack_unf;
    push_we = 1'b0;
    if (state == S_PRIME) begin
      if (!stall) begin
        ir_nxt  = rom_data;
        vld_nxt = 1'b1;
        pc_nxt  = pc + 11'd1;
      end
    end else if (state == S_RUN && !stall) begin
      if (!ir_valid) begin
        // bubble: refill, skip is not looked at
        ir_nxt  = rom_data;
        vld_nxt = 1'b1;
        pc_nxt  = pc + 11'd1;
      end else if (is_goto) begin
        pc_nxt  = ir[10:0];
        ir_nxt  = '0;
        vld_nxt = 1'b0;
      end else if (is_call) begin
        ovf_nxt = stack_ovf | full;
        ir_nxt  = '0;
        vld_nxt = 1'b0;
        if (!(TRAP && full)) begin
          push_we = 1'b1;
          sp_nxt  = sp + SP_ONE;
          pc_nxt  = ir[10:0];
          if (!full) cnt_nxt = cnt + CNT_ONE;
        end
      end else if (is_ret || is_retlw) begin
        unf_nxt = stack_unf | empty;
        ir_nxt  = '0;
        vld_nxt = 1'b0;
        if (!(TRAP && empty)) begin
          pc_nxt = stack[sp_m1];
          sp_nxt = sp_m1;
          if (!empty) cnt_nxt = cnt - CNT_ONE;
          if (is_retlw) begin
            wl_nxt = 1'b1;
            k_nxt  = ir[7:0];
          end
        end
      end else if (skip) begin
        // drop the word at pc; the bubble refills from pc+1
        pc_nxt  = pc + 11'd1;
        ir_nxt  = '0;
        vld_nxt = 1'b0;
      end else begin
        ir_nxt  = rom_data;
        vld_nxt = 1'b1;
        pc_nxt  = pc + 11'd1;
      end
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      ir        <= '0;
      ir_valid  <= 1'b0;
      sp        <= '0;
      cnt       <= '0;
      w_load    <= 1'b0;
      retlw_k   <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      ir_valid  <= vld_nxt;
      sp        <= sp_nxt;
      cnt       <= cnt_nxt;
      w_load    <= wl_nxt;
      retlw_k   <= k_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Return stack storage; a push at full overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset && push_we) stack[sp] <= pc;
  end

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Directed bench for pic_fetch_sequencer: a ROM array in the bench feeds
// rom_data; each task loads a small program and checks hand-computed results.
module tb_pic_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic        stall;
  logic        skip;
  logic [13:0] ir;
  logic        ir_valid;
  logic        w_load;
  logic [7:0]  retlw_k;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [0:2047];
  int checks = 0;
  int errors = 0;

  assign rom_data = rom[rom_addr];

  pic_fetch_sequencer dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .skip(skip), .ir(ir), .ir_valid(ir_valid),
    .w_load(w_load), .retlw_k(retlw_k), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  // Leaves the bench at a falling edge with the DUT in PRIME
  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; skip = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 14'h300F; rom[1] = 14'h00A4;
    do_reset();
    checks++; if (rom_addr !== 11'h000) begin errors++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
    checks++; if (ir_valid !== 1'b0 || ir !== 14'h0000) begin errors++; $display("FAIL reset_ir got v=%b ir=%h want v=0 ir=0000", ir_valid, ir); end
    checks++; if ({w_load, retlw_k, stack_ovf, stack_unf} !== 11'd0) begin errors++; $display("FAIL reset_flags got wl=%b k=%h o=%b u=%b want zeros", w_load, retlw_k, stack_ovf, stack_unf); end
    stall = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 11'h000) begin errors++; $display("FAIL prime_stall got v=%b pc=%h want v=0 pc=000", ir_valid, rom_addr); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (ir !== 14'h300F || ir_valid !== 1'b1 || rom_addr !== 11'h001) begin errors++; $display("FAIL first_fetch got ir=%h v=%b pc=%h want 300F 1 001", ir, ir_valid, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h00A4 || rom_addr !== 11'h002) begin errors++; $display("FAIL second_fetch got ir=%h pc=%h want 00A4 002", ir, rom_addr); end
  endtask

  task automatic test_call_return();
    clear_rom();
    rom[7] = 14'h2014; rom[8] = 14'h1234;
    rom[11'h014] = 14'h301E; rom[11'h015] = 14'h0008;
    do_reset();
    repeat (8) @(negedge clk);
    checks++; if (ir !== 14'h2014 || rom_addr !== 11'h008) begin errors++; $display("FAIL call_fetch got ir=%h pc=%h want 2014 008", ir, rom_addr); end
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 11'h014) begin errors++; $display("FAIL call_bubble got v=%b pc=%h want 0 014", ir_valid, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h301E || ir_valid !== 1'b1 || rom_addr !== 11'h015) begin errors++; $display("FAIL call_target got ir=%h v=%b pc=%h want 301E 1 015", ir, ir_valid, rom_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 11'h008) begin errors++; $display("FAIL return_bubble got v=%b pc=%h want 0 008", ir_valid, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h1234 || rom_addr !== 11'h009 || w_load !== 1'b0) begin errors++; $display("FAIL return_target got ir=%h pc=%h wl=%b want 1234 009 0", ir, rom_addr, w_load); end
  endtask

  task automatic test_goto();
    clear_rom();
    rom[9] = 14'h2803; rom[3] = 14'h1111; rom[10] = 14'h3FFF;
    do_reset();
    repeat (10) @(negedge clk);
    skip = 1'b1;  // flow change must win over skip
    @(negedge clk);
    skip = 1'b0;
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 11'h003) begin errors++; $display("FAIL goto_bubble got v=%b pc=%h want 0 003", ir_valid, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h1111 || rom_addr !== 11'h004) begin errors++; $display("FAIL goto_target got ir=%h pc=%h want 1111 004", ir, rom_addr); end
    do_reset();
    repeat (11) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || ir !== 14'h0000 || rom_addr !== 11'h003) begin errors++; $display("FAIL goto_stall got v=%b ir=%h pc=%h want 0 0000 003", ir_valid, ir, rom_addr); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (ir !== 14'h1111 || ir_valid !== 1'b1 || rom_addr !== 11'h004) begin errors++; $display("FAIL goto_stall_target got ir=%h v=%b pc=%h want 1111 1 004", ir, ir_valid, rom_addr); end
  endtask

  task automatic test_retlw();
    clear_rom();
    rom[0] = 14'h2020; rom[1] = 14'h1234; rom[11'h020] = 14'h3455;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (ir !== 14'h3455 || w_load !== 1'b0) begin errors++; $display("FAIL retlw_fetch got ir=%h wl=%b want 3455 0", ir, w_load); end
    @(negedge clk);
    checks++; if (w_load !== 1'b1 || retlw_k !== 8'h55 || rom_addr !== 11'h001 || ir_valid !== 1'b0) begin errors++; $display("FAIL retlw_exec got wl=%b k=%h pc=%h v=%b want 1 55 001 0", w_load, retlw_k, rom_addr, ir_valid); end
    @(negedge clk);
    checks++; if (w_load !== 1'b0 || ir !== 14'h1234 || rom_addr !== 11'h002) begin errors++; $display("FAIL retlw_after got wl=%b ir=%h pc=%h want 0 1234 002", w_load, ir, rom_addr); end
  endtask

  task automatic test_skip();
    clear_rom();
    rom[11'h010] = 14'h0A10; rom[11'h011] = 14'h3FFF; rom[11'h012] = 14'h0B12;
    do_reset();
    repeat (17) @(negedge clk);
    checks++; if (ir !== 14'h0A10 || rom_addr !== 11'h011) begin errors++; $display("FAIL skip_pre got ir=%h pc=%h want 0A10 011", ir, rom_addr); end
    skip = 1'b1;  // held through the bubble, where it must be ignored
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 11'h012) begin errors++; $display("FAIL skip_bubble got v=%b pc=%h want 0 012", ir_valid, rom_addr); end
    @(negedge clk);
    skip = 1'b0;
    checks++; if (ir !== 14'h0B12 || ir_valid !== 1'b1 || rom_addr !== 11'h013) begin errors++; $display("FAIL skip_after got ir=%h v=%b pc=%h want 0B12 1 013", ir, ir_valid, rom_addr); end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = 14'h2FFE; rom[11'h7FE] = 14'h1111; rom[11'h7FF] = 14'h0222;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (ir !== 14'h1111 || rom_addr !== 11'h7FF) begin errors++; $display("FAIL wrap_7fe got ir=%h pc=%h want 1111 7FF", ir, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h0222 || rom_addr !== 11'h000) begin errors++; $display("FAIL wrap_7ff got ir=%h pc=%h want 0222 000", ir, rom_addr); end
    @(negedge clk);
    checks++; if (ir !== 14'h2FFE || rom_addr !== 11'h001) begin errors++; $display("FAIL wrap_0 got ir=%h pc=%h want 2FFE 001", ir, rom_addr); end
  endtask

  // CALLs at even addresses, RETURNs at the odd return addresses
  task automatic test_stack_overflow();
    clear_rom();
    for (int k = 0; k < 9; k++) begin
      rom[2*k]   = 14'h2000 | 14'(2*k + 2);
      rom[2*k+1] = 14'h0008;
    end
    rom[18] = 14'h0008;
    do_reset();
    repeat (17) @(negedge clk);
    checks++; if (stack_ovf !== 1'b0 || ir !== 14'h2012) begin errors++; $display("FAIL ovf_pre got o=%b ir=%h want 0 2012", stack_ovf, ir); end
    @(negedge clk);
`ifdef STACK_OVF_TRAP_EN
    checks++; if (stack_ovf !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== 11'd17) begin errors++; $display("FAIL ovf_trap got o=%b v=%b pc=%h want 1 0 011", stack_ovf, ir_valid, rom_addr); end
    repeat (5) @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || ir !== 14'h0000 || rom_addr !== 11'd17) begin errors++; $display("FAIL ovf_halt got v=%b ir=%h pc=%h want 0 0000 011", ir_valid, ir, rom_addr); end
`else
    checks++; if (stack_ovf !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== 11'd18) begin errors++; $display("FAIL ovf_set got o=%b v=%b pc=%h want 1 0 012", stack_ovf, ir_valid, rom_addr); end
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 11'd17) begin errors++; $display("FAIL ovf_pop1 got pc=%h want 011", rom_addr); end
    repeat (14) @(negedge clk);
    checks++; if (rom_addr !== 11'd3 || stack_unf !== 1'b0) begin errors++; $display("FAIL ovf_pop8 got pc=%h u=%b want 003 0", rom_addr, stack_unf); end
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 11'd17 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin errors++; $display("FAIL unf_pop9 got pc=%h u=%b o=%b want 011 1 1", rom_addr, stack_unf, stack_ovf); end
`endif
    do_reset();
    checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0 || ir_valid !== 1'b0 || rom_addr !== 11'h000) begin errors++; $display("FAIL flags_clear got o=%b u=%b v=%b pc=%h want 0 0 0 000", stack_ovf, stack_unf, ir_valid, rom_addr); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; skip = 1'b0;
    clear_rom();
    test_reset();
    test_call_return();
    test_goto();
    test_retlw();
    test_skip();
    test_pc_wrap();
    test_stack_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_fetch_sequencer.md
Name: pic_fetch_sequencer

Overview:
Instruction-fetch and program-flow controller for the 14-bit-wide, 2K-word program ROM (11-bit address) in the PIC16-style core. It owns the program counter, the instruction register and an 8-level hardware return stack. It decodes the control-flow opcodes GOTO, CALL, RETURN, RETLW and RETFIE, and inserts one-cycle NOP bubbles on flow changes and on ALU skip requests. The execute stage consumes ir/ir_valid; the ROM is a pure combinational lookup driven by rom_addr.

Parameters:
STACK_DEPTH, 8, return-stack entries (power of 2); stack pointer width = log2(STACK_DEPTH)
RESET_VECTOR, 11'h000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
rom_addr  output  11  program ROM address; combinational copy of pc
rom_data  input  14  ROM instruction word for rom_addr, same cycle
stall  input  1  hold all state this cycle (execute stage busy)
skip  input  1  ALU result: discard next instruction; sampled only when ir_valid=1
ir  output  14  instruction currently in execute
ir_valid  output  1  ir is a real instruction (0 = bubble/NOP)
w_load  output  1  one-cycle pulse: load W with retlw_k (RETLW executed)
retlw_k  output  8  literal from RETLW, valid when w_load=1
stack_ovf  output  1  sticky: push attempted with STACK_DEPTH entries in use
stack_unf  output  1  sticky: pop attempted with stack empty

Behaviour:
- One clock domain. Reset is synchronous and active-high and overrides everything, including stall and an in-flight flow change.
- Reset values: pc=RESET_VECTOR, ir=14'h0000, ir_valid=0, sp=0, count=0, w_load=0, retlw_k=0, stack_ovf=0, stack_unf=0, state=PRIME.
- States: PRIME → RUN. RUN has a sub-condition "bubble" when ir_valid=0. HALT exists only with the optional feature.
- PRIME, one cycle after reset:
  - ir<=rom_data, ir_valid<=1, pc<=pc+1, go to RUN.
  - stall holds PRIME.
- Invariant: while ir holds the instruction fetched from address A, pc=A+1 (mod 2048).
- RUN with stall=1: pc, ir, ir_valid, sp and stack all hold; w_load=0.
- RUN with stall=0. Decode ir only when ir_valid=1, first match wins:
  - GOTO (ir[13:11]=3'b101): pc<=ir[10:0]; ir<=0; ir_valid<=0.
  - CALL (ir[13:11]=3'b100): stack[sp]<=pc; sp<=sp+1; pc<=ir[10:0]; bubble as GOTO.
  - RETURN (14'h0008) or RETFIE (14'h0009): pc<=stack[sp-1]; sp<=sp-1; bubble.
  - RETLW (ir[13:10]=4'b1101): as RETURN, plus w_load<=1 and retlw_k<=ir[7:0] for exactly one cycle.
  - Any other instruction with skip=1: pc<=pc+1 (drops the word at pc); ir<=0; ir_valid<=0.
  - Otherwise: ir<=rom_data; ir_valid<=1; pc<=pc+1.
- Bubble cycle (ir_valid=0, stall=0): no decode; ir<=rom_data, ir_valid<=1, pc<=pc+1. skip is ignored.
- Latency and throughput:
  - Flow-change instruction: 2 cycles.
  - Skip taken: 2 cycles.
  - All others: 1 cycle.
  - First valid ir: 1 cycle after reset deasserts.
- skip asserted together with a flow-change decode: the flow change wins and skip is ignored.
- PC arithmetic is 11-bit and wraps 11'h7FF → 11'h000 without error.
- Stack is a circular buffer. sp is log2(STACK_DEPTH) bits and wraps; a separate occupancy count saturates at 0 and STACK_DEPTH.
  - Push at full: the write overwrites the oldest entry, and stack_ovf sets.
  - Pop at empty: sp still decrements (wraps), the returned value is whatever is stored there, and stack_unf sets.
  - Sticky flags clear only on reset.

Optional Feature:
STACK_OVF_TRAP_EN
- Defined: a push at full or a pop at empty does not change pc, sp or the stack. It sets the sticky flag, forces ir=0 and ir_valid=0, and enters HALT. HALT holds all state until reset; rom_addr stays frozen.
- Undefined: wrap behaviour as above; no HALT state is synthesised.

Test Plan:
1. Reset with ROM 0x000=14'h300F, 0x001=14'h00A4 → first cycle: rom_addr=0x000, ir_valid=0. Next cycles: ir=0x300F with pc=0x001, then ir=0x00A4 with pc=0x002.
2. ROM 0x007=14'h2014 (CALL 0x014), 0x014=14'h301E, 0x015=14'h0008:
   - On CALL: bubble, then ir=0x301E.
   - stack[0]=0x008.
   - RETURN: bubble, then ir=ROM[0x008] and pc=0x009; sp back to 0.
3. ROM 0x009=14'h2803 (GOTO 3) → one bubble cycle, then ir=ROM[0x003], pc=0x004. Repeat with stall held 3 cycles during the bubble: all outputs frozen, same result.
4. RETLW 14'h3455 → w_load=1 for exactly one cycle with retlw_k=0x55, and pc restored from the stack.
5. skip=1 while ir=ROM[0x010] → word at 0x011 never appears in ir; ir_valid=0 for one cycle, then ir=ROM[0x012].
6. Nine nested CALLs → stack_ovf=1. Without the macro, the 9th return address overwrites entry 0. With STACK_OVF_TRAP_EN, ir_valid stays 0 and pc stays frozen until reset.
